// File: rtl/eth_rx_pkg.sv
// rtl/eth_rx_pkg.sv - shared constants and state encoding for the UDP receive controller
// Contents: ETH_TYPE_IPV4, default board IP / UDP port, receive FSM state type.
package eth_rx_pkg;

   localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
   localparam logic [31:0] DEF_BOARD_IP  = 32'hC0A8_0002;
   localparam logic [15:0] DEF_UDP_PORT  = 16'd8080;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      CHECK = 2'd2
   } rx_state_t;

endpackage

// File: rtl/udp_rx_ctrl_if.sv
// rtl/udp_rx_ctrl_if.sv - packet output stream between the controller and its consumer
// Signals: out_data (32) payload word, out_valid word present, out_ready consumer accepts,
//          out_last final word of packet. master = producer, slave = consumer.
interface udp_rx_ctrl_if;

   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;

   modport master (output out_data, output out_valid, output out_last, input out_ready);
   modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/udp_rx_desc_fifo.sv
// rtl/udp_rx_desc_fifo.sv - 4-entry x 16-bit FIFO of committed packet word counts
// Ports: clk, rst_n (async active-low), push/push_data write side, pop read side,
//        head = oldest entry (show-ahead), full/empty flags.
module udp_rx_desc_fifo (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  logic [15:0] push_data,
   input  logic        pop,
   output logic [15:0] head,
   output logic        full,
   output logic        empty
);

   logic [15:0] mem [4];
   logic [2:0]  wr_idx;
   logic [2:0]  rd_idx;

   // Extra index bit distinguishes full from empty when the low bits match.
   assign full  = (wr_idx[1:0] == rd_idx[1:0]) && (wr_idx[2] != rd_idx[2]);
   assign empty = (wr_idx == rd_idx);
   assign head  = mem[rd_idx[1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_idx <= 3'd0;
         rd_idx <= 3'd0;
         for (int i = 0; i < 4; i++) mem[i] <= 16'd0;
      end else begin
         if (push && !full) begin
            mem[wr_idx[1:0]] <= push_data;
            wr_idx           <= wr_idx + 3'd1;
         end
         if (pop && !empty) rd_idx <= rd_idx + 3'd1;
      end
   end

endmodule

// File: rtl/udp_rx_ctrl.sv
// rtl/udp_rx_ctrl.sv - UDP receive controller: arms receiver, buffers frames, commits or drops, streams packets out
// Ports: clk, rst_n (async active-low); rx_word/rx_word_valid/rx_finish from the receiver;
//        ip_prtcl/board_ip/udp_hdr frame headers; rx_arm re-arm pulse; stream (master) packet output;
//        pkt_ok_cnt/pkt_drop_cnt saturating counters; ovf sticky word-loss flag.
module udp_rx_ctrl
   import eth_rx_pkg::*;
#(
   parameter logic [31:0] BOARD_IP      = DEF_BOARD_IP,
   parameter logic [15:0] UDP_PORT      = DEF_UDP_PORT,
   parameter int          DEPTH_LOG2    = 9,
   parameter logic [15:0] MAX_PKT_WORDS = 16'd368
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          rx_word,
   input  logic                 rx_word_valid,
   input  logic                 rx_finish,
   input  logic [15:0]          ip_prtcl,
   input  logic [31:0]          board_ip,
   input  logic [63:0]          udp_hdr,
   output logic                 rx_arm,
   udp_rx_ctrl_if.master        stream,
   output logic [15:0]          pkt_ok_cnt,
   output logic [15:0]          pkt_drop_cnt,
   output logic                 ovf
);

   localparam int              AW      = DEPTH_LOG2;
   localparam logic [AW:0]     DEPTH   = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0]     PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [31:0] mem [0:(1 << AW) - 1];

   rx_state_t   state;
   logic [AW:0] wr_ptr, commit_ptr, rd_ptr, rd_next;
   logic [AW:0] used, free;
   logic        full, word_edge, accept, rx_valid_q, frame_ovf;
   logic [15:0] word_cnt, sent, remaining, desc_head;
   logic        desc_full, desc_empty, desc_push, desc_pop;
   logic        valid_q, fire;
   logic        unused_hdr;

   assign unused_hdr = ^{udp_hdr[63:48], udp_hdr[31:0]};

   assign used      = wr_ptr - rd_ptr;
   assign free      = DEPTH - used;
   assign full      = (used == DEPTH);
   assign word_edge = rx_word_valid && !rx_valid_q;
   assign accept    = (ip_prtcl == ETH_TYPE_IPV4) && (board_ip == BOARD_IP) &&
                      (udp_hdr[47:32] == UDP_PORT) && !frame_ovf && (word_cnt != 16'd0);
   assign desc_push = (state == CHECK) && accept;

   // Receive FSM: words are written speculatively; CHECK either publishes
   // them by moving commit_ptr or discards them by rolling wr_ptr back.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         rx_arm       <= 1'b0;
         rx_valid_q   <= 1'b0;
         word_cnt     <= 16'd0;
         frame_ovf    <= 1'b0;
         ovf          <= 1'b0;
         wr_ptr       <= '0;
         commit_ptr   <= '0;
         pkt_ok_cnt   <= 16'd0;
         pkt_drop_cnt <= 16'd0;
      end else begin
         rx_valid_q <= rx_word_valid;
         rx_arm     <= 1'b0;
         case (state)
            IDLE: begin
               // Only re-arm when a maximum-size frame is guaranteed to fit.
               if ((32'(free) >= 32'(MAX_PKT_WORDS)) && !desc_full) begin
                  rx_arm    <= 1'b1;
                  frame_ovf <= 1'b0;
                  word_cnt  <= 16'd0;
                  state     <= RECV;
               end
            end
            RECV: begin
               if (word_edge) begin
                  if (!full) begin
                     wr_ptr   <= wr_ptr + PTR_ONE;
                     word_cnt <= word_cnt + 16'd1;
                  end else begin
                     frame_ovf <= 1'b1;
                     ovf       <= 1'b1;
                  end
               end
               if (rx_finish) state <= CHECK;
            end
            CHECK: begin
               if (accept) begin
                  commit_ptr <= wr_ptr;
                  if (pkt_ok_cnt != 16'hFFFF) pkt_ok_cnt <= pkt_ok_cnt + 16'd1;
               end else begin
                  wr_ptr <= commit_ptr;
                  if (pkt_drop_cnt != 16'hFFFF) pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if ((state == RECV) && word_edge && !full) mem[wr_ptr[AW-1:0]] <= rx_word;
   end

   udp_rx_desc_fifo u_desc (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (desc_push),
      .push_data (word_cnt),
      .pop       (desc_pop),
      .head      (desc_head),
      .full      (desc_full),
      .empty     (desc_empty)
   );

   // Read side: the output register always holds the word at the pointer
   // that will be current next cycle, so a transfer refills it without a bubble.
   assign fire      = stream.out_valid && stream.out_ready;
   assign rd_next   = fire ? rd_ptr + PTR_ONE : rd_ptr;
   assign remaining = desc_head - sent;
   assign stream.out_valid = valid_q && !desc_empty;
   assign stream.out_last  = stream.out_valid && (remaining == 16'd1);
   assign desc_pop  = fire && stream.out_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr          <= '0;
         sent            <= 16'd0;
         valid_q         <= 1'b0;
         stream.out_data <= 32'd0;
      end else begin
         rd_ptr          <= rd_next;
         valid_q         <= (rd_next != commit_ptr);
         stream.out_data <= mem[rd_next[AW-1:0]];
         if (desc_pop)  sent <= 16'd0;
         else if (fire) sent <= sent + 16'd1;
      end
   end

endmodule

// File: doc/udp_rx_ctrl.md
Name: udp_rx_ctrl

Overview:
Controller and packet buffer behind the MII receive front-end (`iprecieve`).
- Re-arms the receiver with a one-cycle pulse on its `tx_finish` input.
- Speculatively stores incoming 32-bit payload words, then commits or drops the whole frame once `rx_finish` arrives, based on IPv4 ethertype, destination IP and UDP destination port.
- Presents committed packets to the downstream consumer over a valid/ready stream with a last-word marker, plus status counters.

Parameters:
- BOARD_IP, 32'hC0A8_0002, accepted destination IPv4 address.
- UDP_PORT, 16'd8080, accepted UDP destination port.
- DEPTH_LOG2, 9, payload buffer depth is 2**DEPTH_LOG2 words.
- MAX_PKT_WORDS, 16'd368, free words required before re-arming the receiver.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- rx_word, input, 32, payload word from the receiver.
- rx_word_valid, input, 1, word strobe; a write happens only on its rising edge.
- rx_finish, input, 1, end-of-frame pulse from the receiver.
- ip_prtcl, input, 16, ethertype of the current frame.
- board_ip, input, 32, destination IP of the current frame.
- udp_hdr, input, 64, UDP header: [47:32] destination port, [31:16] length.
- rx_arm, output, 1, one-cycle pulse that re-arms the receiver.
- out_data, output, 32, payload word to the consumer.
- out_valid, output, 1, out_data is valid.
- out_ready, input, 1, consumer accepts the word.
- out_last, output, 1, current word is the last word of its packet.
- pkt_ok_cnt, output, 16, accepted packets, saturating.
- pkt_drop_cnt, output, 16, dropped packets, saturating.
- ovf, output, 1, sticky flag: a word was lost because the buffer was full.

Behaviour:
- Reset (async, rst_n=0): all outputs, pointers, counters and the state register go to 0; state = IDLE. Reset mid-frame discards all buffered and committed data.
- Pointers:
  - wr_ptr, commit_ptr and rd_ptr are DEPTH_LOG2+1 bits wide and wrap modulo 2**(DEPTH_LOG2+1).
  - used = wr_ptr - rd_ptr.
  - full when used == 2**DEPTH_LOG2.
- IDLE:
  - If (2**DEPTH_LOG2 - used) >= MAX_PKT_WORDS and the descriptor FIFO is not full: assert rx_arm for exactly 1 cycle, clear frame_ovf and word_cnt, go to RECV.
  - Otherwise stay in IDLE with rx_arm=0.
- RECV:
  - On a rising edge of rx_word_valid (rx_word_valid=1 and its registered copy 0):
    - if not full, write rx_word at wr_ptr, increment wr_ptr and word_cnt;
    - if full, discard the word and set frame_ovf and ovf.
  - A level held high for several cycles writes exactly once.
  - On rx_finish go to CHECK. If a word edge coincides with rx_finish, the word is written first, in the same cycle.
- CHECK (1 cycle):
  - accept = ip_prtcl==16'h0800 && board_ip==BOARD_IP && udp_hdr[47:32]==UDP_PORT && !frame_ovf && word_cnt!=0.
  - accept: commit_ptr <= wr_ptr; push word_cnt into the descriptor FIFO; pkt_ok_cnt++ (saturating at 16'hFFFF).
  - reject: wr_ptr <= commit_ptr (rollback); pkt_drop_cnt++ (saturating).
  - Go to IDLE. Latency from rx_finish to the first possible out_valid is 3 cycles.
- rx_finish seen outside RECV is ignored.
- Read side (runs concurrently with receive):
  - out_valid=1 when rd_ptr != commit_ptr and the descriptor FIFO is non-empty.
  - out_data is the buffer word at rd_ptr, held in a registered output stage with prefetch.
  - out_data and out_last stay stable while out_valid && !out_ready.
  - On out_valid && out_ready: rd_ptr++, remaining--.
  - out_last=1 when remaining==1. On that transfer, pop the descriptor and load the next packet's count.
- ovf stays set until reset.

Decomposition:
- Package eth_rx_pkg holds:
  - ETH_TYPE_IPV4 = 16'h0800;
  - the state encoding IDLE / RECV / CHECK;
  - default BOARD_IP and UDP_PORT constants.
- Sub-module udp_rx_desc_fifo: 4-entry x 16-bit synchronous FIFO of packet word counts, with full/empty flags and async active-low reset.
- The payload RAM is inferred inline.

Test Plan:
- Matching frame, 5 words (0x11111111..0x55555555), out_ready=1 → 5 transfers in order, out_last only on 0x55555555, pkt_ok_cnt=1, rx_arm pulsed once before and once after.
- ip_prtcl=16'h0806 with 3 words → no out_valid, wr_ptr returns to its prior value, pkt_drop_cnt=1.
- rx_word_valid held high 4 cycles, then a final word edge in the same cycle as rx_finish → exactly 2 words stored and committed.
- DEPTH_LOG2=4, MAX_PKT_WORDS=4, out_ready=0, send matching frames → no rx_arm once free < 4, or once 4 descriptors are queued; a frame longer than the free space sets ovf and is dropped.
- Back-to-back packets of 2 and 3 words, out_ready toggling 1010… → data stable while stalled, out_last on words 2 and 5.
- Assert rst_n=0 mid-RECV → all outputs 0 immediately; after release a new frame is received cleanly.
